cp0_exc_ctrl: RTL and testbench

Exception/ERET sequencer and CP0 write-port arbiter.
- Sits between the MEM stage and the CP0 register file.
- Accepts synchronous exceptions, pending hardware interrupts and ERET from MEM, and serialises the required EPC/Cause/Status updates over the single CP0 write port.
- Stalls, then flushes, the pipeline with the redirect PC.
- When idle, passes MTC0 writes from the pipeline through to CP0.

---
 rtl/cp0_exc_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/ERET sequencer and CP0 write-port arbiter.
// Serialises EPC/Cause/Status updates for exceptions, interrupts and ERET over the
// single CP0 write port, stalls then flushes the pipeline with the redirect PC,
// and forwards pipeline MTC0 writes while idle.
// Optional: define CP0_EXC_CNT_EN to add a saturating exception counter (exc_count_o).
module cp0_exc_ctrl #(
  parameter int unsigned         DATA_W     = 32,
  parameter logic [DATA_W-1:0]   EXC_VECTOR = 32'h00000020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid_i,
  input  logic [4:0]        exc_code_i,
  input  logic              eret_i,
  input  logic              inst_valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              in_delay_i,
  input  logic              mtc0_we_i,
  input  logic [4:0]        mtc0_addr_i,
  input  logic [DATA_W-1:0] mtc0_data_i,
  input  logic [DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0] cause_i,
  input  logic [DATA_W-1:0] epc_i,
  output logic              cp0_we_o,
  output logic [4:0]        cp0_waddr_o,
  output logic [DATA_W-1:0] cp0_data_o,
  output logic              cp0_exc_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] new_pc_o,
`ifdef CP0_EXC_CNT_EN
  output logic [15:0]       exc_count_o,
`endif
  output logic              busy_o
);

  localparam logic [4:0]        AddrStatus = 5'd12;
  localparam logic [4:0]        AddrCause  = 5'd13;
  localparam logic [4:0]        AddrEpc    = 5'd14;
  localparam logic [DATA_W-1:0] ExlMask    = DATA_W'(2);
  localparam logic [DATA_W-1:0] PcStep     = DATA_W'(4);

  typedef enum logic [2:0] {
    StIdle,
    StWrEpc,
    StWrCause,
    StWrStatus,
    StEret,
    StRedirect
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [4:0]        code_q, code_d;
  logic              exl_q, exl_d;
  logic [DATA_W-1:0] new_pc_q, new_pc_d;

  logic              int_pend;
  logic              exc_evt;
  logic [DATA_W-1:0] cause_w;

  // Next-state, event capture and CP0 write-port muxing.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bd_d        = bd_q;
    code_d      = code_q;
    exl_d       = exl_q;
    new_pc_d    = new_pc_q;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_data_o  = '0;
    cp0_exc_o   = 1'b0;
    cause_w     = cause_i;

    int_pend = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8])) & inst_valid_i;
    exc_evt  = int_pend | exc_valid_i;

    unique case (state_q)
      StIdle: begin
        if (exc_evt || eret_i) begin
          // Any same-cycle MTC0 is dropped; the write port stays quiet this cycle.
          pc_d   = pc_i;
          bd_d   = in_delay_i;
          code_d = int_pend ? 5'd0 : (exc_valid_i ? exc_code_i : 5'd0);
          exl_d  = status_i[1];
          if (exc_evt) begin
            state_d = status_i[1] ? StWrCause : StWrEpc;
          end else begin
            state_d = StEret;
          end
        end else begin
          cp0_we_o    = mtc0_we_i;
          cp0_waddr_o = mtc0_addr_i;
          cp0_data_o  = mtc0_data_i;
        end
      end
      StWrEpc: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = AddrEpc;
        cp0_data_o  = bd_q ? (pc_q - PcStep) : pc_q;
        cp0_exc_o   = 1'b1;
        state_d     = StWrCause;
      end
      StWrCause: begin
        // With EXL already set, the original BD must survive the nested exception.
        cause_w[31]  = exl_q ? cause_i[31] : bd_q;
        cause_w[6:2] = code_q;
        cp0_we_o     = 1'b1;
        cp0_waddr_o  = AddrCause;
        cp0_data_o   = cause_w;
        cp0_exc_o    = 1'b1;
        state_d      = StWrStatus;
      end
      StWrStatus: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = AddrStatus;
        cp0_data_o  = status_i | ExlMask;
        cp0_exc_o   = 1'b1;
        new_pc_d    = EXC_VECTOR;
        state_d     = StRedirect;
      end
      StEret: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = AddrStatus;
        cp0_data_o  = status_i & ~ExlMask;
        new_pc_d    = epc_i;
        state_d     = StRedirect;
      end
      StRedirect: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured-event registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      bd_q     <= 1'b0;
      code_q   <= 5'd0;
      exl_q    <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bd_q     <= bd_d;
      code_q   <= code_d;
      exl_q    <= exl_d;
      new_pc_q <= new_pc_d;
    end
  end

`ifdef CP0_EXC_CNT_EN
  logic [15:0] cnt_q;

  // Count completed exception/interrupt sequences, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (state_q == StWrStatus && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign exc_count_o = cnt_q;
`endif

  assign flush_o  = (state_q == StRedirect);
  assign busy_o   = (state_q != StIdle);
  assign stall_o  = busy_o;
  assign new_pc_o = new_pc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Testbench for cp0_exc_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a sequence-list reference model.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic        inst_valid;
  logic [31:0] pc;
  logic        in_delay;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_data;
  logic        cp0_exc;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef CP0_EXC_CNT_EN
  logic [15:0] exc_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(
    .DATA_W    (32),
    .EXC_VECTOR(32'h00000020)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_valid_i (exc_valid),
    .exc_code_i  (exc_code),
    .eret_i      (eret),
    .inst_valid_i(inst_valid),
    .pc_i        (pc),
    .in_delay_i  (in_delay),
    .mtc0_we_i   (mtc0_we),
    .mtc0_addr_i (mtc0_addr),
    .mtc0_data_i (mtc0_data),
    .status_i    (status),
    .cause_i     (cause),
    .epc_i       (epc),
    .cp0_we_o    (cp0_we),
    .cp0_waddr_o (cp0_waddr),
    .cp0_data_o  (cp0_data),
    .cp0_exc_o   (cp0_exc),
    .stall_o     (stall),
    .flush_o     (flush),
    .new_pc_o    (new_pc),
`ifdef CP0_EXC_CNT_EN
    .exc_count_o (exc_count),
`endif
    .busy_o      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted event becomes a list of per-cycle actions the block must perform.
  localparam int KEpc = 0, KCause = 1, KStatus = 2, KEret = 3, KRedir = 4;
  int          plan[$];
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_code;
  logic        m_exl;
  logic [31:0] m_last_pc = 32'd0;
  int          m_cnt = 0;
  bit          model_on = 1'b0;

  always @(negedge clk) begin
    logic        e_we, e_exc, e_flush, e_busy, irq, evt;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          kind;
    irq    = status[0] && !status[1] && ((status[15:8] & cause[15:8]) != 8'd0) && inst_valid;
    evt    = irq || exc_valid || eret;
    e_busy = (plan.size() != 0);
    kind   = e_busy ? plan[0] : -1;
    e_we = 1'b0; e_exc = 1'b0; e_flush = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (!e_busy) begin
      if (!evt) begin
        e_we = mtc0_we; e_addr = mtc0_addr; e_data = mtc0_data;
      end
    end else begin
      case (kind)
        KEpc: begin
          e_we = 1'b1; e_exc = 1'b1; e_addr = 5'd14;
          e_data = m_bd ? m_pc - 32'd4 : m_pc;
        end
        KCause: begin
          e_we = 1'b1; e_exc = 1'b1; e_addr = 5'd13;
          e_data = cause;
          e_data[31] = m_exl ? cause[31] : m_bd;
          e_data[6:2] = m_code;
        end
        KStatus: begin
          e_we = 1'b1; e_exc = 1'b1; e_addr = 5'd12; e_data = status | 32'h2;
        end
        KEret: begin
          e_we = 1'b1; e_addr = 5'd12; e_data = status & ~32'h2;
        end
        default: e_flush = 1'b1;
      endcase
    end
    if (model_on) begin
      chk("m_we", {31'd0, cp0_we}, {31'd0, e_we});
      chk("m_waddr", {27'd0, cp0_waddr}, {27'd0, e_addr});
      chk("m_data", cp0_data, e_data);
      chk("m_exc", {31'd0, cp0_exc}, {31'd0, e_exc});
      chk("m_flush", {31'd0, flush}, {31'd0, e_flush});
      chk("m_stall", {31'd0, stall}, {31'd0, e_busy});
      chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("m_new_pc", new_pc, m_last_pc);
`ifdef CP0_EXC_CNT_EN
      chk("m_count", {16'd0, exc_count}, m_cnt);
`endif
    end
    if (rst) begin
      plan.delete();
      m_last_pc = 32'd0;
      m_cnt = 0;
      model_on = 1'b1;
    end else if (e_busy) begin
      void'(plan.pop_front());
      if (kind == KStatus) begin
        m_last_pc = 32'h20;
        if (m_cnt < 65535) m_cnt++;
      end else if (kind == KEret) begin
        m_last_pc = epc;
      end
    end else if (evt) begin
      m_pc = pc; m_bd = in_delay; m_exl = status[1];
      if (irq || exc_valid) begin
        m_code = irq ? 5'd0 : exc_code;
        if (!status[1]) plan.push_back(KEpc);
        plan.push_back(KCause);
        plan.push_back(KStatus);
        plan.push_back(KRedir);
      end else begin
        plan.push_back(KEret);
        plan.push_back(KRedir);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    exc_valid = 1'b0; exc_code = 5'd0; eret = 1'b0; inst_valid = 1'b0;
    pc = 32'd0; in_delay = 1'b0; mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0;
    status = 32'd0; cause = 32'd0; epc = 32'd0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_we", {31'd0, cp0_we}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
`ifdef CP0_EXC_CNT_EN
    chk("rst_count", {16'd0, exc_count}, 32'd0);
`endif

    // Syscall, no EXL, not in delay slot.
    tick(); idle_in();
    status = 32'h10000001; exc_valid = 1'b1; exc_code = 5'd8; pc = 32'h100; #1;
    chk("t1_accept_we", {31'd0, cp0_we}, 32'd0);
    tick(); exc_valid = 1'b0; #1;
    chk("t1_epc_addr", {27'd0, cp0_waddr}, 32'd14);
    chk("t1_epc_data", cp0_data, 32'h100);
    chk("t1_epc_exc", {31'd0, cp0_exc}, 32'd1);
    chk("t1_stall1", {31'd0, stall}, 32'd1);
    tick(); #1;
    chk("t1_cause_addr", {27'd0, cp0_waddr}, 32'd13);
    chk("t1_cause_data", cp0_data, 32'h00000020);
    tick(); #1;
    chk("t1_status_data", cp0_data, 32'h10000003);
    tick(); #1;
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_new_pc", new_pc, 32'h20);
    chk("t1_stall4", {31'd0, stall}, 32'd1);
    tick(); #1;
    chk("t1_stall_done", {31'd0, stall}, 32'd0);

    // Interrupt beats a same-cycle exception; delay-slot EPC correction.
    tick(); idle_in();
    status = 32'h10000401; cause = 32'h00000400; inst_valid = 1'b1; pc = 32'h204;
    in_delay = 1'b1; exc_valid = 1'b1; exc_code = 5'd12;
    tick(); exc_valid = 1'b0; inst_valid = 1'b0; #1;
    chk("t2_epc_data", cp0_data, 32'h200);
    tick(); #1;
    chk("t2_cause_data", cp0_data, 32'h80000400);
    tick(); tick(); #1;
    chk("t2_flush", {31'd0, flush}, 32'd1);
    tick(); idle_in(); #1;
`ifdef CP0_EXC_CNT_EN
    chk("t2_count", {16'd0, exc_count}, 32'd2);
`endif

    // Nested exception (EXL=1) with an MTC0 arriving during the Cause write.
    tick(); idle_in();
    status = 32'h10000003; cause = 32'h80000000; exc_valid = 1'b1; exc_code = 5'd10;
    pc = 32'h300;
    tick(); exc_valid = 1'b0; mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'h50; #1;
    chk("t3_cause_addr", {27'd0, cp0_waddr}, 32'd13);
    chk("t3_cause_data", cp0_data, 32'h80000028);
    tick(); mtc0_we = 1'b0; #1;
    chk("t3_status_addr", {27'd0, cp0_waddr}, 32'd12);
    tick(); #1;
    chk("t3_flush", {31'd0, flush}, 32'd1);

    // MTC0 pass-through while idle.
    tick(); idle_in(); mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'h50; #1;
    chk("mtc0_we", {31'd0, cp0_we}, 32'd1);
    chk("mtc0_addr", {27'd0, cp0_waddr}, 32'd11);
    chk("mtc0_data", cp0_data, 32'h50);
    chk("mtc0_exc", {31'd0, cp0_exc}, 32'd0);

    // ERET.
    tick(); idle_in(); status = 32'h10000003; epc = 32'h344; eret = 1'b1;
    tick(); eret = 1'b0; #1;
    chk("eret_status", cp0_data, 32'h10000001);
    tick(); #1;
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_new_pc", new_pc, 32'h344);

    // Reset while writing Cause abandons the sequence.
    tick(); idle_in(); status = 32'h10000001; exc_valid = 1'b1; exc_code = 5'd13; pc = 32'h400;
    tick(); exc_valid = 1'b0;
    tick(); rst = 1'b1; #1;
    chk("rst_mid_addr", {27'd0, cp0_waddr}, 32'd13);
    tick(); rst = 1'b0; idle_in(); #1;
    chk("rst_mid_we", {31'd0, cp0_we}, 32'd0);
    chk("rst_mid_data", cp0_data, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_new_pc", new_pc, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst        = ($urandom_range(0, 59) == 0);
      exc_valid  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: exc_code = 5'd8;
        1: exc_code = 5'd10;
        2: exc_code = 5'd12;
        default: exc_code = 5'd13;
      endcase
      eret       = ($urandom_range(0, 5) == 0);
      inst_valid = ($urandom_range(0, 2) == 0);
      pc         = $urandom & 32'hFFFFFFFC;
      in_delay   = $urandom_range(0, 1) == 1;
      mtc0_we    = $urandom_range(0, 1) == 1;
      mtc0_addr  = 5'($urandom_range(0, 31));
      mtc0_data  = $urandom;
      status     = $urandom;
      cause      = $urandom;
      epc        = $urandom;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
